k007232_seq: RTL and testbench

//  Host-side command sequencer for the k007232 PCM chip. Two requesters submit
//  "play" commands (channel, pitch, mode, start address, loop). The block

---
 rtl/k007232_pkg.sv | 54 +++++
 rtl/k007232_rr_arb.sv | 19 +
 rtl/k007232_seq.sv | 196 +++++++++++++++++++
 tb/tb_k007232_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/k007232_pkg.sv
// Shared definitions for the k007232 command sequencer: register map, address
// encoding, command record and FSM states.
package k007232_pkg;

  localparam logic [3:0] REG_PRE_LO    = 4'd0;
  localparam logic [3:0] REG_PRE_HI    = 4'd1;
  localparam logic [3:0] REG_START_LO  = 4'd2;
  localparam logic [3:0] REG_START_MID = 4'd3;
  localparam logic [3:0] REG_START_HI  = 4'd4;
  localparam logic [3:0] REG_TRIG      = 4'd5;
  localparam logic [3:0] REG_LOOP      = 4'd13;
  localparam logic [3:0] CH2_OFS       = 4'd6;

  // Write sequence positions: 0..4 channel regs, then loop reg, then trigger.
  localparam logic [2:0] STEP_LOOP = 3'd5;
  localparam logic [2:0] STEP_TRIG = 3'd6;

  typedef struct packed {
    logic        ch;
    logic [11:0] pitch;
    logic [1:0]  mode;
    logic [16:0] start;
    logic        loop;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic logic [3:0] ab_enc(input logic [3:0] idx);
    return {idx[3:1], ~idx[0]};
  endfunction

  function automatic logic [3:0] reg_idx(input logic ch, input logic [2:0] step);
    logic [3:0] base;
    case (step)
      3'd0:    base = REG_PRE_LO;
      3'd1:    base = REG_PRE_HI;
      3'd2:    base = REG_START_LO;
      3'd3:    base = REG_START_MID;
      3'd4:    base = REG_START_HI;
      3'd5:    base = REG_LOOP;
      default: base = REG_TRIG;
    endcase
    // The loop register is shared; every other register has a CH2 copy.
    if (ch && (step != STEP_LOOP)) base = base + CH2_OFS;
    return base;
  endfunction

endpackage

// File: rtl/k007232_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention the
// requester other than the last-granted one (i_ptr) wins.
module k007232_rr_arb (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/k007232_seq.sv
// Host-side command sequencer for the k007232: arbitrates two requesters and
// plays out the register writes for a "play" command, skipping unchanged ones.
module k007232_seq
  import k007232_pkg::*;
#(
  parameter int WR_LEN   = 2,
  parameter int HOLD_LEN = 1
) (
  input  logic        CLK,
  input  logic        NRES,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [1:0]  REQ_CH,
  input  logic [23:0] REQ_PITCH,
  input  logic [3:0]  REQ_MODE,
  input  logic [33:0] REQ_START,
  input  logic [1:0]  REQ_LOOP,
  output logic        DACS,
  output logic [3:0]  AB,
  output logic [7:0]  DB,
  output logic        DB_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        GNT_ID
);

  localparam int CNT_W = 8;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_step;
  cmd_t             r_cmd;
  logic             r_dacs;
  logic [3:0]       r_ab;
  logic [7:0]       r_db;
  logic             r_db_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_gnt_id;
  logic [7:0]       r_sh [2][5];
  logic [4:0]       r_sv [2];
  logic [1:0]       r_loop_sh;
  logic             r_loop_vld;

  logic [1:0] w_gnt;
  logic       w_sel;
  logic       w_hs;
  logic       w_hold_end;
  cmd_t       w_req_cmd;
  cmd_t       w_cmd;
  logic [1:0] w_loop_base;
  logic [1:0] w_loop_new;
  logic [7:0] w_val [7];
  logic [6:0] w_need;
  logic [2:0] w_from;
  logic [2:0] w_next;

  k007232_rr_arb u_arb (
    .i_valid (REQ_VALID),
    .i_ptr   (r_gnt_id),
    .o_gnt   (w_gnt)
  );

  assign REQ_READY  = (r_state == ST_IDLE) ? w_gnt : 2'b00;
  assign w_sel      = w_gnt[1];
  assign w_hs       = |(REQ_VALID & REQ_READY);
  assign w_hold_end = (r_state == ST_HOLD) && (r_cnt == '0);

  always_comb begin
    w_req_cmd       = '0;
    w_req_cmd.ch    = REQ_CH[w_sel];
    w_req_cmd.pitch = w_sel ? REQ_PITCH[23:12] : REQ_PITCH[11:0];
    w_req_cmd.mode  = w_sel ? REQ_MODE[3:2]    : REQ_MODE[1:0];
    w_req_cmd.start = w_sel ? REQ_START[33:17] : REQ_START[16:0];
    w_req_cmd.loop  = REQ_LOOP[w_sel];
  end

  // In IDLE the write plan is built from the incoming command, otherwise from
  // the latched one; the same lookup serves the first and every later write.
  assign w_cmd       = (r_state == ST_IDLE) ? w_req_cmd : r_cmd;
  assign w_from      = (r_state == ST_IDLE) ? 3'd0 : r_step + 3'd1;
  assign w_loop_base = r_loop_vld ? r_loop_sh : 2'b00;
  assign w_loop_new  = w_cmd.ch ? {w_cmd.loop, w_loop_base[0]}
                                : {w_loop_base[1], w_cmd.loop};

  always_comb begin
    w_val[0] = w_cmd.pitch[7:0];
    w_val[1] = {2'b00, w_cmd.mode, w_cmd.pitch[11:8]};
    w_val[2] = w_cmd.start[7:0];
    w_val[3] = w_cmd.start[15:8];
    w_val[4] = {7'b0, w_cmd.start[16]};
    w_val[5] = {6'b0, w_loop_new};
    w_val[6] = 8'h00;
  end

  always_comb begin
    w_need = '0;
    for (int k = 0; k < 5; k++)
      w_need[k] = !(r_sv[w_cmd.ch][k] && (r_sh[w_cmd.ch][k] == w_val[k]));
    w_need[5] = !(r_loop_vld && (r_loop_sh == w_loop_new));
    w_need[6] = 1'b1;
  end

  // Lowest needed step at or after w_from; the trigger always qualifies.
  always_comb begin
    w_next = STEP_TRIG;
    for (int k = 5; k >= 0; k--)
      if (w_need[k] && (3'(k) >= w_from)) w_next = 3'(k);
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_step     <= 3'd0;
      r_dacs     <= 1'b1;
      r_ab       <= 4'd0;
      r_db       <= 8'd0;
      r_db_oe    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gnt_id   <= 1'b1;
      r_sv[0]    <= '0;
      r_sv[1]    <= '0;
      r_loop_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_gnt_id <= w_sel;
            r_busy   <= 1'b1;
            r_step   <= w_next;
            r_ab     <= ab_enc(reg_idx(w_cmd.ch, w_next));
            r_db     <= w_val[w_next];
            r_db_oe  <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_dacs  <= 1'b0;
          r_cnt   <= CNT_W'(WR_LEN - 1);
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            r_dacs  <= 1'b1;
            r_cnt   <= CNT_W'(HOLD_LEN - 1);
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            if (r_step < STEP_LOOP)       r_sv[r_cmd.ch][r_step] <= 1'b1;
            else if (r_step == STEP_LOOP) r_loop_vld <= 1'b1;
            if (r_step == STEP_TRIG) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_db_oe <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_step  <= w_next;
              r_ab    <= ab_enc(reg_idx(w_cmd.ch, w_next));
              r_db    <= w_val[w_next];
              r_state <= ST_SETUP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Command and shadow contents need no reset: valid flags gate their use.
  always_ff @(posedge CLK) begin
    if ((r_state == ST_IDLE) && w_hs) r_cmd <= w_req_cmd;
    if (w_hold_end && (r_step < STEP_LOOP)) r_sh[r_cmd.ch][r_step] <= r_db;
    if (w_hold_end && (r_step == STEP_LOOP)) r_loop_sh <= r_db[1:0];
  end

  assign DACS   = r_dacs;
  assign AB     = r_ab;
  assign DB     = r_db;
  assign DB_OE  = r_db_oe;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign GNT_ID = r_gnt_id;

endmodule

// File: tb/tb_k007232_seq.sv
// Directed bench for k007232_seq: table of play commands with hand-derived
// AB/DB write lists, plus arbitration and mid-write reset sequences.
module tb_k007232_seq;

  logic        CLK = 1'b0;
  logic        NRES = 1'b0;
  logic [1:0]  REQ_VALID = '0;
  logic [1:0]  REQ_READY;
  logic [1:0]  REQ_CH = '0;
  logic [23:0] REQ_PITCH = '0;
  logic [3:0]  REQ_MODE = '0;
  logic [33:0] REQ_START = '0;
  logic [1:0]  REQ_LOOP = '0;
  logic        DACS;
  logic [3:0]  AB;
  logic [7:0]  DB;
  logic        DB_OE;
  logic        BUSY;
  logic        DONE;
  logic        GNT_ID;

  k007232_seq #(.WR_LEN(2), .HOLD_LEN(1)) dut (
    .CLK       (CLK),
    .NRES      (NRES),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_CH    (REQ_CH),
    .REQ_PITCH (REQ_PITCH),
    .REQ_MODE  (REQ_MODE),
    .REQ_START (REQ_START),
    .REQ_LOOP  (REQ_LOOP),
    .DACS      (DACS),
    .AB        (AB),
    .DB        (DB),
    .DB_OE     (DB_OE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .GNT_ID    (GNT_ID)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected writes are packed first-write-first as 12-bit {AB, DB} words.
  typedef struct {
    int          req;
    logic        ch;
    logic [11:0] pitch;
    logic [1:0]  mode;
    logic [16:0] start;
    logic        loop;
    int          nw;
    logic [83:0] wr;
  } vec_t;

  vec_t        vecs [8];
  logic [11:0] got  [8];
  int          got_n, got_busy, got_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic ch, input logic [11:0] pitch,
                         input logic [1:0] mode, input logic [16:0] start, input logic lp);
    REQ_CH[r]             = ch;
    REQ_PITCH[12*r +: 12] = pitch;
    REQ_MODE[2*r +: 2]    = mode;
    REQ_START[17*r +: 17] = start;
    REQ_LOOP[r]           = lp;
  endtask

  task automatic handshake(input int r);
    int cyc = 0;
    #1;
    while (!(REQ_VALID[r] && REQ_READY[r]) && (cyc < 50)) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    chk("handshake_ready", {31'd0, REQ_READY[r]}, 32'd1);
    @(posedge CLK);
    #1;
    REQ_VALID[r] = 1'b0;
  endtask

  task automatic collect();
    logic prev = 1'b1;
    bit   seen = 1'b0;
    got_n = 0; got_busy = 0; got_first = 0;
    for (int cyc = 1; (cyc <= 300) && !seen; cyc++) begin
      @(negedge CLK);
      if (BUSY) got_busy++;
      if (prev && !DACS) begin
        if (got_n == 0) got_first = cyc;
        if (got_n < 8) got[got_n[2:0]] = {AB, DB};
        chk("db_oe_in_strobe", {31'd0, DB_OE}, 32'd1);
        got_n++;
      end
      prev = DACS;
      if (DONE) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(negedge CLK);
    chk("done_pulse_width", {31'd0, DONE}, 32'd0);
    chk("busy_after_done", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic check_writes(input string name, input int nw, input logic [83:0] wr);
    chk({name, "_nwrites"}, got_n, nw);
    for (int k = 0; (k < nw) && (k < got_n) && (k < 7); k++)
      chk({name, "_write"}, {20'd0, got[k]}, {20'd0, wr[83-12*k -: 12]});
    chk({name, "_busy_cycles"}, got_busy, 4 * nw);
    chk({name, "_first_fall"}, got_first, 32'd2);
  endtask

  task automatic check_idle_reset(input string name);
    chk({name, "_dacs"},  {31'd0, DACS}, 32'd1);
    chk({name, "_ab_db"}, {20'd0, AB, DB}, 32'd0);
    chk({name, "_db_oe"}, {31'd0, DB_OE}, 32'd0);
    chk({name, "_ready"}, {30'd0, REQ_READY}, 32'd0);
    chk({name, "_busy"},  {31'd0, BUSY}, 32'd0);
    chk({name, "_done"},  {31'd0, DONE}, 32'd0);
    chk({name, "_gnt"},   {31'd0, GNT_ID}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 12'h123, 2'd0, 17'h1ABCD, 1'b1, 7, 84'h123_001_3CD_2AB_501_C01_400};
    vecs[1] = '{0, 1'b0, 12'h123, 2'd0, 17'h1ABCD, 1'b1, 1, {12'h400, 72'd0}};
    vecs[2] = '{1, 1'b1, 12'h0FF, 2'd0, 17'h00010, 1'b0, 6, {72'h7FF_600_910_800_B00_A00, 12'd0}};
    vecs[3] = '{0, 1'b0, 12'h145, 2'd0, 17'h1ABCD, 1'b1, 2, {24'h145_400, 60'd0}};
    vecs[4] = '{1, 1'b0, 12'h145, 2'd3, 17'h1ABCD, 1'b1, 2, {24'h031_400, 60'd0}};
    vecs[5] = '{0, 1'b0, 12'h145, 2'd3, 17'h1ABCD, 1'b0, 2, {24'hC00_400, 60'd0}};
    vecs[6] = '{1, 1'b1, 12'h0FF, 2'd0, 17'h10010, 1'b0, 2, {24'hB01_A00, 60'd0}};
    vecs[7] = '{0, 1'b1, 12'h0FF, 2'd0, 17'h10010, 1'b1, 2, {24'hC02_A00, 60'd0}};

    // Reset values, then quiet idle for 10 cycles
    repeat (2) @(negedge CLK);
    check_idle_reset("in_reset");
    NRES = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      check_idle_reset("idle");
    end

    // Table of commands applied back to back
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].req, vecs[i].ch, vecs[i].pitch, vecs[i].mode, vecs[i].start, vecs[i].loop);
      REQ_VALID[vecs[i].req] = 1'b1;
      handshake(vecs[i].req);
      chk("vec_gnt_id", {31'd0, GNT_ID}, vecs[i].req);
      chk("vec_busy_on_accept", {31'd0, BUSY}, 32'd1);
      collect();
      check_writes("vec", vecs[i].nw, vecs[i].wr);
    end

    // Contention after reset: req0 first, then req1, then req0 again
    NRES = 1'b0;
    @(negedge CLK);
    NRES = 1'b1;
    @(negedge CLK);
    set_req(0, 1'b0, 12'h123, 2'd0, 17'h1ABCD, 1'b1);
    set_req(1, 1'b1, 12'h0FF, 2'd0, 17'h00010, 1'b0);
    REQ_VALID = 2'b11;
    #1;
    chk("arb_first_ready", {30'd0, REQ_READY}, 32'h1);
    handshake(0);
    chk("arb_first_gnt", {31'd0, GNT_ID}, 32'd0);
    collect();
    check_writes("arb_req0", 7, vecs[0].wr);
    #1;
    chk("arb_second_ready", {30'd0, REQ_READY}, 32'h2);
    handshake(1);
    chk("arb_second_gnt", {31'd0, GNT_ID}, 32'd1);
    collect();
    check_writes("arb_req1", 6, vecs[2].wr);
    REQ_VALID = 2'b11;
    #1;
    chk("arb_third_ready", {30'd0, REQ_READY}, 32'h1);
    handshake(0);
    REQ_VALID = 2'b00;
    chk("arb_third_gnt", {31'd0, GNT_ID}, 32'd0);
    collect();
    check_writes("arb_req0_again", 1, vecs[1].wr);

    // Reset in the middle of a strobe, then a full replay
    set_req(0, 1'b0, 12'h123, 2'd0, 17'h1ABCD, 1'b1);
    REQ_VALID[0] = 1'b1;
    handshake(0);
    @(negedge CLK);
    chk("abort_setup_dacs", {31'd0, DACS}, 32'd1);
    @(negedge CLK);
    chk("abort_strobe_dacs", {31'd0, DACS}, 32'd0);
    #2;
    NRES = 1'b0;
    #1;
    chk("abort_async_dacs", {31'd0, DACS}, 32'd1);
    chk("abort_async_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_async_db_oe", {31'd0, DB_OE}, 32'd0);
    @(negedge CLK);
    NRES = 1'b1;
    @(negedge CLK);
    REQ_VALID[0] = 1'b1;
    handshake(0);
    collect();
    check_writes("replay", 7, vecs[0].wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
